// File: rtl/ctrl_unit_mc.sv
// Multi-cycle RV32I sequencer: fetch / decode / execute over a Wishbone-style port.
// Optional CTRL_SUBWORD_EN adds byte/halfword loads and stores with alignment traps.
module ctrl_unit_mc #(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              wb_cs,
  output logic              wb_we,
  output logic [3:0]        wb_sel,
  output logic [31:0]       wb_wdata,
  input  logic [31:0]       wb_rdata,
  input  logic              wb_ack,
  output logic [4:0]        rs1_id,
  output logic [4:0]        rs2_id,
  input  logic [31:0]       rs1_data,
  input  logic [31:0]       rs2_data,
  output logic [4:0]        rd_id,
  output logic [31:0]       rd_data,
  output logic              rd_write,
  output logic [3:0]        alu_control,
  output logic              alu_enable,
  output logic [31:0]       imm_data,
  output logic              imm_enable,
  output logic [ADDR_W-1:0] pc,
  output logic              illegal
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EX_R, EX_I, EX_L, EX_S, EX_JAL, EX_JALR, EX_B, EX_U, TRAP
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc_q;
  logic [31:0]        instr;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [31:0] iimm, simm, bimm, jimm, uimm, imm_sel;
  logic        is_store;
  logic [31:0] mem_addr, jalr_tgt;
  logic [ADDR_W-1:0] pc4;

  assign opcode   = instr[6:0];
  assign f3       = instr[14:12];
  assign iimm     = {{20{instr[31]}}, instr[31:20]};
  assign simm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign bimm     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign jimm     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign uimm     = {instr[31:12], 12'b0};
  assign is_store = opcode[5];
  assign mem_addr = rs1_data + (is_store ? simm : iimm);
  assign jalr_tgt = (rs1_data + iimm) & ~32'd1;
  assign pc4      = pc_q + ADDR_W'(4);

  always_comb begin
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111: imm_sel = iimm;
      7'b0100011:                         imm_sel = simm;
      7'b1100011:                         imm_sel = bimm;
      7'b1101111:                         imm_sel = jimm;
      7'b0110111, 7'b0010111:             imm_sel = uimm;
      default:                            imm_sel = '0;
    endcase
  end

  logic [3:0]  lane_sel;
  logic        ls_ok, misalign;
  logic [31:0] load_data, store_data;
`ifdef CTRL_SUBWORD_EN
  logic [1:0]  ofs;
  logic [31:0] shifted;
  assign ofs     = mem_addr[1:0];
  assign shifted = wb_rdata >> {ofs, 3'b000};
  always_comb begin
    case (f3[1:0])
      2'b00:   lane_sel = 4'b0001 << ofs;
      2'b01:   lane_sel = ofs[1] ? 4'b1100 : 4'b0011;
      default: lane_sel = 4'hF;
    endcase
    ls_ok    = is_store ? (f3 inside {3'b000, 3'b001, 3'b010})
                        : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign = (f3[1:0] == 2'b01 && ofs[0]) || (f3[1:0] == 2'b10 && ofs != 2'b00);
    case (f3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'b0, shifted[7:0]};
      3'b101:  load_data = {16'b0, shifted[15:0]};
      default: load_data = wb_rdata;
    endcase
    case (f3[1:0])
      2'b00:   store_data = {4{rs2_data[7:0]}};
      2'b01:   store_data = {2{rs2_data[15:0]}};
      default: store_data = rs2_data;
    endcase
  end
`else
  assign lane_sel   = 4'hF;
  assign ls_ok      = (f3 == 3'b010);
  assign misalign   = 1'b0;
  assign load_data  = wb_rdata;
  assign store_data = rs2_data;
`endif

  logic taken;
  always_comb begin
    case (f3)
      3'b000:  taken = rs1_data == rs2_data;
      3'b001:  taken = rs1_data != rs2_data;
      3'b100:  taken = $signed(rs1_data) <  $signed(rs2_data);
      3'b101:  taken = $signed(rs1_data) >= $signed(rs2_data);
      3'b110:  taken = rs1_data <  rs2_data;
      3'b111:  taken = rs1_data >= rs2_data;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc_q  <= RESET_VECTOR[ADDR_W-1:0];
      instr <= '0;
    end else begin
      case (state)
        IDLE:  state <= FETCH;
        FETCH: if (wb_ack) begin
          instr <= wb_rdata;
          state <= DECODE;
        end
        DECODE: case (opcode)
          7'b0110011:             state <= EX_R;
          7'b0010011:             state <= EX_I;
          7'b0000011:             state <= (ls_ok && !misalign) ? EX_L : TRAP;
          7'b0100011:             state <= (ls_ok && !misalign) ? EX_S : TRAP;
          7'b1101111:             state <= EX_JAL;
          7'b1100111:             state <= EX_JALR;
          7'b1100011:             state <= (f3[2:1] == 2'b01) ? TRAP : EX_B;
          7'b0110111, 7'b0010111: state <= EX_U;
          default:                state <= TRAP;
        endcase
        EX_L, EX_S: if (wb_ack) begin
          pc_q  <= pc4;
          state <= FETCH;
        end
        EX_JAL: begin
          pc_q  <= pc_q + jimm[ADDR_W-1:0];
          state <= FETCH;
        end
        EX_JALR: begin
          pc_q  <= jalr_tgt[ADDR_W-1:0];
          state <= FETCH;
        end
        EX_B: begin
          pc_q  <= taken ? pc_q + bimm[ADDR_W-1:0] : pc4;
          state <= FETCH;
        end
        default: begin
          pc_q  <= pc4;
          state <= FETCH;
        end
      endcase
    end
  end

  // Outputs are decoded from state so a reset drops the bus request immediately.
  always_comb begin
    wb_addr = '0; wb_cs = 1'b0; wb_we = 1'b0; wb_sel = 4'h0; wb_wdata = '0;
    rs1_id = '0; rs2_id = '0; rd_id = '0; rd_data = '0; rd_write = 1'b0;
    alu_control = '0; alu_enable = 1'b0; imm_data = '0; imm_enable = 1'b0;
    pc = '0; illegal = 1'b0;
    if (state != IDLE) begin
      rs1_id   = instr[19:15];
      rs2_id   = instr[24:20];
      rd_id    = instr[11:7];
      imm_data = imm_sel;
      pc       = pc_q;
    end
    case (state)
      FETCH: begin
        wb_cs = 1'b1; wb_addr = pc_q; wb_sel = 4'hF;
      end
      EX_R: begin
        alu_enable = 1'b1; rd_write = 1'b1; alu_control = {instr[30], f3};
      end
      EX_I: begin
        alu_enable = 1'b1; rd_write = 1'b1; imm_enable = 1'b1;
        alu_control = {(f3 == 3'b101) & instr[30], f3};
      end
      EX_L: begin
        wb_cs = 1'b1; wb_addr = mem_addr[ADDR_W-1:0]; wb_sel = lane_sel;
        rd_write = wb_ack; rd_data = load_data;
      end
      EX_S: begin
        wb_cs = 1'b1; wb_we = 1'b1; wb_addr = mem_addr[ADDR_W-1:0];
        wb_sel = lane_sel; wb_wdata = store_data;
      end
      EX_JAL, EX_JALR: begin
        rd_write = 1'b1; rd_data = 32'(pc4);
      end
      EX_U: begin
        rd_write = 1'b1;
        rd_data  = opcode[5] ? uimm : uimm + 32'(pc_q);
      end
      TRAP: illegal = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ctrl_unit_mc.sv
// Directed bench for ctrl_unit_mc: 16-bit addresses, reset vector 0x0001_0010 (-> 0x0010).
module tb_ctrl_unit_mc;
  localparam int AW = 16;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic [AW-1:0] wb_addr, pc;
  logic          wb_cs, wb_we, wb_ack, rd_write, alu_enable, imm_enable, illegal;
  logic [3:0]    wb_sel, alu_control;
  logic [31:0]   wb_wdata, wb_rdata, rs1_data, rs2_data, rd_data, imm_data;
  logic [4:0]    rs1_id, rs2_id, rd_id;
  int            n_run = 0, n_fail = 0;

  ctrl_unit_mc #(.ADDR_W(AW), .RESET_VECTOR(32'h0001_0010)) dut (
    .clk(clk), .rst_n(rst_n), .wb_addr(wb_addr), .wb_cs(wb_cs), .wb_we(wb_we),
    .wb_sel(wb_sel), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata), .wb_ack(wb_ack),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_id(rd_id), .rd_data(rd_data), .rd_write(rd_write), .alu_control(alu_control),
    .alu_enable(alu_enable), .imm_data(imm_data), .imm_enable(imm_enable),
    .pc(pc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Leaves the bench just after a falling edge with the DUT in FETCH at the reset vector.
  task automatic do_reset();
    rst_n = 1'b0; wb_ack = 1'b0; wb_rdata = '0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  // Called in FETCH; returns just after the falling edge of the EX (or TRAP) cycle.
  task automatic issue(input logic [31:0] ins);
    wb_rdata = ins; wb_ack = 1'b1;
    @(negedge clk); wb_ack = 1'b0; wb_rdata = '0;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    n_run++;
    if ({wb_cs, wb_we, wb_sel, wb_addr, rd_write, alu_enable, illegal, pc} !== '0) begin
      n_fail++; $display("FAIL reset_idle got cs=%b sel=%h addr=%h pc=%h want all 0", wb_cs, wb_sel, wb_addr, pc);
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_run++;
    if ({wb_cs, wb_we, wb_sel, wb_addr, pc} !== {1'b1, 1'b0, 4'hF, 16'h0010, 16'h0010}) begin
      n_fail++; $display("FAIL first_fetch got cs=%b sel=%h addr=%h pc=%h want 1 f 0010 0010", wb_cs, wb_sel, wb_addr, pc);
    end
    @(negedge clk); #1;
    n_run++;
    if ({wb_cs, wb_addr} !== {1'b1, 16'h0010}) begin
      n_fail++; $display("FAIL fetch_wait got cs=%b addr=%h want 1 0010", wb_cs, wb_addr);
    end
    rst_n = 1'b0; #1;
    n_run++;
    if ({wb_cs, wb_sel} !== 5'b0) begin
      n_fail++; $display("FAIL reset_midfetch got cs=%b sel=%h want 0 0", wb_cs, wb_sel);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_run++;
    if ({wb_cs, wb_addr} !== {1'b1, 16'h0010}) begin
      n_fail++; $display("FAIL refetch got cs=%b addr=%h want 1 0010", wb_cs, wb_addr);
    end
  endtask

  task automatic test_alu();
    rs1_data = 32'd0; rs2_data = 32'd0;
    issue(32'h0050_0093);                        // addi x1,x0,5
    n_run++;
    if ({alu_enable, imm_enable, rd_write, alu_control, rd_id, imm_data, pc, wb_cs}
        !== {3'b111, 4'h0, 5'd1, 32'd5, 16'h0010, 1'b0}) begin
      n_fail++; $display("FAIL addi_ex got en=%b%b%b ctl=%h rd=%0d imm=%h pc=%h want 111 0 1 5 0010",
                         alu_enable, imm_enable, rd_write, alu_control, rd_id, imm_data, pc);
    end
    @(negedge clk); #1;
    n_run++;
    if ({pc, wb_addr, wb_cs} !== {16'h0014, 16'h0014, 1'b1}) begin
      n_fail++; $display("FAIL addi_pc got pc=%h addr=%h want 0014", pc, wb_addr);
    end
    issue(32'h4000_0093);                        // addi x1,x0,1024: bit30 set, alt must stay 0
    n_run++;
    if ({alu_control, imm_data} !== {4'h0, 32'h400}) begin
      n_fail++; $display("FAIL addi_bit30 got ctl=%h imm=%h want 0 400", alu_control, imm_data);
    end
    @(negedge clk); #1;
    issue(32'h4030_D093);                        // srai x1,x1,3
    n_run++;
    if ({alu_control, imm_enable, rs1_id} !== {4'hD, 1'b1, 5'd1}) begin
      n_fail++; $display("FAIL srai got ctl=%h immen=%b rs1=%0d want d 1 1", alu_control, imm_enable, rs1_id);
    end
    @(negedge clk); #1;
    issue(32'h4020_81B3);                        // sub x3,x1,x2
    n_run++;
    if ({alu_control, alu_enable, imm_enable, rd_id, rs1_id, rs2_id} !== {4'h8, 2'b10, 5'd3, 5'd1, 5'd2}) begin
      n_fail++; $display("FAIL sub got ctl=%h en=%b%b rd=%0d rs=%0d,%0d want 8 10 3 1,2",
                         alu_control, alu_enable, imm_enable, rd_id, rs1_id, rs2_id);
    end
    @(negedge clk); #1;
    n_run++;
    if (pc !== 16'h0020) begin
      n_fail++; $display("FAIL sub_pc got %h want 0020", pc);
    end
  endtask

  task automatic test_branch();
    do_reset();
    rs1_data = 32'd3; rs2_data = 32'd3;
    issue(32'hFE20_9CE3);                        // bne x1,x2,-8
    n_run++;
    if ({imm_data, rd_write, alu_enable} !== {32'hFFFF_FFF8, 2'b00}) begin
      n_fail++; $display("FAIL bne_imm got imm=%h wr=%b alu=%b want fffffff8 0 0", imm_data, rd_write, alu_enable);
    end
    @(negedge clk); #1;
    n_run++;
    if (pc !== 16'h0014) begin
      n_fail++; $display("FAIL bne_not_taken got %h want 0014", pc);
    end
    do_reset();
    rs1_data = 32'd4;
    issue(32'hFE20_9CE3);
    @(negedge clk); #1;
    n_run++;
    if ({pc, wb_addr} !== {16'h0008, 16'h0008}) begin
      n_fail++; $display("FAIL bne_taken got pc=%h addr=%h want 0008", pc, wb_addr);
    end
    rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd1;
    issue(32'hFE20_CCE3);                        // blt: -1 < 1 taken
    @(negedge clk); #1;
    n_run++;
    if (pc !== 16'h0000) begin
      n_fail++; $display("FAIL blt_taken got %h want 0000", pc);
    end
    issue(32'hFE20_ECE3);                        // bltu: 0xffffffff < 1 not taken
    @(negedge clk); #1;
    n_run++;
    if (pc !== 16'h0004) begin
      n_fail++; $display("FAIL bltu_not_taken got %h want 0004", pc);
    end
    issue(32'hFE20_FCE3);                        // bgeu taken, wraps below zero
    @(negedge clk); #1;
    n_run++;
    if (pc !== 16'hFFFC) begin
      n_fail++; $display("FAIL bgeu_wrap got %h want fffc", pc);
    end
  endtask

  task automatic test_jump_upper();
    do_reset();
    rs1_data = 32'h101; rs2_data = 32'd0;
    issue(32'h0081_00E7);                        // jalr x1,8(x2)
    n_run++;
    if ({rd_write, rd_data, rd_id, rs1_id} !== {1'b1, 32'h14, 5'd1, 5'd2}) begin
      n_fail++; $display("FAIL jalr_link got wr=%b data=%h rd=%0d rs1=%0d want 1 14 1 2", rd_write, rd_data, rd_id, rs1_id);
    end
    @(negedge clk); #1;
    n_run++;
    if (pc !== 16'h0108) begin
      n_fail++; $display("FAIL jalr_pc got %h want 0108", pc);
    end
    issue(32'h0100_02EF);                        // jal x5,+16
    n_run++;
    if ({rd_write, rd_data, rd_id} !== {1'b1, 32'h10C, 5'd5}) begin
      n_fail++; $display("FAIL jal_link got wr=%b data=%h rd=%0d want 1 10c 5", rd_write, rd_data, rd_id);
    end
    @(negedge clk); #1;
    n_run++;
    if (pc !== 16'h0118) begin
      n_fail++; $display("FAIL jal_pc got %h want 0118", pc);
    end
    issue(32'h1234_51B7);                        // lui x3,0x12345
    n_run++;
    if ({rd_write, rd_data} !== {1'b1, 32'h1234_5000}) begin
      n_fail++; $display("FAIL lui got wr=%b data=%h want 1 12345000", rd_write, rd_data);
    end
    @(negedge clk); #1;
    issue(32'h0000_1217);                        // auipc x4,1 at 0x11c
    n_run++;
    if ({rd_write, rd_data} !== {1'b1, 32'h111C}) begin
      n_fail++; $display("FAIL auipc got wr=%b data=%h want 1 111c", rd_write, rd_data);
    end
    @(negedge clk); #1;
    n_run++;
    if (pc !== 16'h0120) begin
      n_fail++; $display("FAIL auipc_pc got %h want 0120", pc);
    end
  endtask

  task automatic test_load_store();
    rs1_data = 32'h1000;
    issue(32'h0040_A283);                        // lw x5,4(x1), three wait states
    for (int i = 0; i < 3; i++) begin
      n_run++;
      if ({wb_cs, wb_we, wb_addr, wb_sel, rd_write, pc} !== {2'b10, 16'h1004, 4'hF, 1'b0, 16'h0120}) begin
        n_fail++; $display("FAIL lw_wait%0d got cs=%b we=%b addr=%h sel=%h wr=%b pc=%h want 1 0 1004 f 0 0120",
                           i, wb_cs, wb_we, wb_addr, wb_sel, rd_write, pc);
      end
      @(negedge clk); #1;
    end
    wb_rdata = 32'hDEAD_BEEF; wb_ack = 1'b1; #1;
    n_run++;
    if ({wb_cs, rd_write, rd_data, rd_id} !== {2'b11, 32'hDEAD_BEEF, 5'd5}) begin
      n_fail++; $display("FAIL lw_ack got cs=%b wr=%b data=%h rd=%0d want 1 1 deadbeef 5", wb_cs, rd_write, rd_data, rd_id);
    end
    @(negedge clk); wb_ack = 1'b0; wb_rdata = '0; #1;
    n_run++;
    if ({pc, wb_addr, wb_we} !== {16'h0124, 16'h0124, 1'b0}) begin
      n_fail++; $display("FAIL lw_pc got pc=%h addr=%h we=%b want 0124 0124 0", pc, wb_addr, wb_we);
    end
    rs1_data = 32'h2000; rs2_data = 32'hCAFE_F00D;
    issue(32'h0020_A423);                        // sw x2,8(x1), zero wait
    wb_ack = 1'b1; #1;
    n_run++;
    if ({wb_cs, wb_we, wb_addr, wb_sel, wb_wdata, rd_write} !== {2'b11, 16'h2008, 4'hF, 32'hCAFE_F00D, 1'b0}) begin
      n_fail++; $display("FAIL sw got cs=%b we=%b addr=%h sel=%h wdata=%h wr=%b want 1 1 2008 f cafef00d 0",
                         wb_cs, wb_we, wb_addr, wb_sel, wb_wdata, rd_write);
    end
    @(negedge clk); wb_ack = 1'b0; #1;
    n_run++;
    if (pc !== 16'h0128) begin
      n_fail++; $display("FAIL sw_pc got %h want 0128", pc);
    end
  endtask

  task automatic test_illegal();
    rs1_data = 32'd0; rs2_data = 32'd0;
    issue(32'hFFFF_FFFF);
    wb_ack = 1'b1;                               // stray ack with no request
    n_run++;
    if ({illegal, rd_write, wb_cs, wb_we, pc} !== {4'b1000, 16'h0128}) begin
      n_fail++; $display("FAIL trap_op got ill=%b wr=%b cs=%b we=%b pc=%h want 1 0 0 0 0128",
                         illegal, rd_write, wb_cs, wb_we, pc);
    end
    @(negedge clk); wb_ack = 1'b0; #1;
    n_run++;
    if ({illegal, pc, wb_cs} !== {1'b0, 16'h012C, 1'b1}) begin
      n_fail++; $display("FAIL trap_end got ill=%b pc=%h cs=%b want 0 012c 1", illegal, pc, wb_cs);
    end
    issue(32'h0000_2063);                        // branch funct3=010
    n_run++;
    if ({illegal, rd_write} !== 2'b10) begin
      n_fail++; $display("FAIL trap_branch got ill=%b wr=%b want 1 0", illegal, rd_write);
    end
    @(negedge clk); #1;
    rs1_data = 32'd3;
    issue(32'h0001_1083);                        // lh x1,0(x2) at 0x3
    n_run++;
    if ({illegal, rd_write, wb_cs} !== 3'b100) begin
      n_fail++; $display("FAIL trap_lh got ill=%b wr=%b cs=%b want 1 0 0", illegal, rd_write, wb_cs);
    end
    @(negedge clk); #1;
    n_run++;
    if (pc !== 16'h0134) begin
      n_fail++; $display("FAIL trap_lh_pc got %h want 0134", pc);
    end
`ifdef CTRL_SUBWORD_EN
    rs1_data = 32'h1000;
    issue(32'h0011_4083);                        // lbu x1,1(x2)
    wb_rdata = 32'h1234_AB78; wb_ack = 1'b1; #1;
    n_run++;
    if ({wb_sel, rd_write, rd_data} !== {4'b0010, 1'b1, 32'h0000_00AB}) begin
      n_fail++; $display("FAIL lbu got sel=%b wr=%b data=%h want 0010 1 000000ab", wb_sel, rd_write, rd_data);
    end
    @(negedge clk); wb_ack = 1'b0; wb_rdata = '0; #1;
`endif
  endtask

  initial begin
    wb_ack = 1'b0; wb_rdata = '0; rs1_data = '0; rs2_data = '0;
    test_reset();
    test_alu();
    test_branch();
    test_jump_upper();
    test_load_store();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/ctrl_unit_mc.md
# ctrl_unit_mc

Parametrised multi-cycle RV32I control unit; the next generation of the core's sequencer. Fetches instructions over the Wishbone-style bus, decodes them and drives the register file, ALU and memory port. Adds branches, JALR, LUI/AUIPC, illegal-instruction trapping, a configurable reset vector and address width, and optional sub-word loads and stores. Sits between the bus master port and the register file/ALU datapath.

## Interface
- ADDR_W, 32, bus/PC address width (12..32)
- RESET_VECTOR, 32'h0, PC value after reset (truncated to ADDR_W)

- Clk  in  1  clock, all state on rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Wb_addr  out  ADDR_W  bus address
- Wb_cs  out  1  bus request
- Wb_we  out  1  write enable
- Wb_sel  out  4  byte lane enables
- Wb_wdata  out  32  write data
- Wb_rdata  in  32  read data
- Wb_ack  in  1  transfer complete (same-cycle ack allowed)
- Rs1_id, Rs2_id  out  5  source register ids
- Rs1_data, Rs2_data  in  32  source register data
- Rd_id  out  5  destination id
- Rd_data  out  32  destination data (non-ALU writes)
- Rd_write  out  1  destination write strobe
- Alu_control  out  4  ALU op, {alt bit, funct3}
- Alu_enable  out  1  ALU result drives Rd
- Imm_data  out  32  sign-extended immediate
- Imm_enable  out  1  ALU operand B = Imm_data
- Pc  out  ADDR_W  PC of the current instruction
- Illegal  out  1  one-cycle pulse on undecodable instruction

## Operation
- States: IDLE, FETCH, DECODE, EX_R, EX_I, EX_L, EX_S, EX_JAL, EX_JALR, EX_B, EX_U, TRAP.
- IDLE -> FETCH unconditionally. FETCH: Wb_cs=1, Wb_addr=Pc, Wb_sel=4'hF; on Wb_ack latch instr, -> DECODE.
- DECODE dispatches on opcode: 0110011 R, 0010011 I, 0000011 L, 0100011 S, 1101111 JAL, 1100111 JALR, 1100011 B, 0110111/0010111 U; anything else -> TRAP.
- EX_R/EX_I: Alu_enable=1, Rd_write=1; Alu_control = {funct7[5], funct3} for R; for I, alt bit = funct7[5] only when funct3=101, else 0. EX_I sets Imm_enable. Pc += 4.
- EX_L: Wb_addr=Rs1_data+Iimm, hold Wb_cs until Wb_ack; Rd_write=Wb_ack, Rd_data=load data; then Pc += 4.
- EX_S: Wb_we=1, Wb_addr=Rs1_data+Simm, hold until ack; Pc += 4.
- EX_JAL: Rd_data=Pc+4, Rd_write=1, Pc += Jimm. EX_JALR: Rd_data=Pc+4, Pc = (Rs1_data+Iimm) & ~1.
- EX_B: funct3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; taken -> Pc += Bimm, else Pc += 4. funct3 010/011 -> TRAP (decided in DECODE).
- EX_U: LUI Rd_data=Uimm; AUIPC Rd_data=Pc+Uimm; Rd_write=1; Pc += 4.
- TRAP: Illegal=1 for one cycle, no writes, Pc += 4, -> FETCH.
- Rd_write asserts even when rd=x0; register file discards it.
- All address arithmetic modulo 2^ADDR_W; upper address bits of 32-bit sums dropped.

## Timing
- Reset (Rst_n low, async): state=IDLE, Pc=RESET_VECTOR, instr=0. Outputs are combinational from state: in IDLE every output is 0 (Wb_sel=0).
- Reset mid-transfer: Wb_cs drops in the same cycle Rst_n falls; no completion recorded.
- First fetch request: cycle after Rst_n deasserts (IDLE lasts 1 cycle).
- Zero-wait bus: ALU/jump/branch/U instruction = 3 cycles (FETCH, DECODE, EX); load/store = 3 + wait states in EX; each FETCH wait state adds 1.
- Wb_ack without Wb_cs is ignored. Outputs stable while waiting for ack.
- Pc and next state update on the EX edge; Pc output equals instruction address throughout FETCH..EX.

## Configuration
- CTRL_SUBWORD_EN defined: LB/LH/LW/LBU/LHU and SB/SH/SW. Wb_sel from funct3 and addr[1:0]; load data shifted down and sign/zero-extended; store data replicated across lanes. Misaligned half (addr[0]=1) or word (addr[1:0]≠0) -> TRAP, no bus cycle.
- Undefined: only LW/SW; Wb_sel=4'hF always; other L/S funct3 -> TRAP; address low bits passed unchecked.

## Test plan
- Reset: Rst_n low mid-FETCH with Wb_cs=1 -> Wb_cs=0 same cycle; after release Wb_addr=RESET_VECTOR on first FETCH.
- ADDI x1,x0,5 with zero-wait memory -> Alu_enable, Imm_enable, Imm_data=5, Rd_id=1 in cycle 3; Pc advances by 4.
- BNE with Rs1=3, Rs2=3 at Pc=0x10, offset -8 -> not taken, Pc=0x14; Rs1=4 -> Pc=0x08.
- JALR x1,8(x2), Rs1_data=0x101 -> Rd_data=Pc+4, Pc=0x108.
- LW with 3 wait states -> Wb_cs held 4 cycles, Rd_write only on ack cycle, Rd_data=Wb_rdata.
- Opcode 7'b1111111 -> Illegal pulses one cycle, no Rd_write/Wb_cs, Pc += 4; with CTRL_SUBWORD_EN, LH at addr 0x3 -> same trap response.
